// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the switch debouncer.
package switch_debouncer_pkg;

   localparam int STABLE_CYCLES_DEF = 50000;
   localparam int CNT_W_DEF         = 16;

   typedef enum logic [1:0] {
      LOW       = 2'd0,
      RISE_WAIT = 2'd1,
      HIGH      = 2'd2,
      FALL_WAIT = 2'd3
   } db_state_e;

   // Level that the sampled input must reach to advance the given state.
   function automatic logic target_level(db_state_e s);
      return (s == LOW) || (s == RISE_WAIT);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Reusable for any asynchronous input in the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic sync1_d, sync1_q;
   logic sync2_d, sync2_q;

   // Next values: shift the raw level through two stages.
   always_comb begin
      sync1_d = d;
      sync2_d = sync1_q;
   end

   // Synchronizer stages, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign q = sync2_q;

endmodule

// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronizes a bouncing switch, accepts a level change
// only after STABLE_CYCLES consecutive samples, and drives a clean level
// (d_out) plus a one-cycle load strobe (e_out) for an enabled D register.
// Build option: define SWITCH_DEBOUNCE_FALL_STROBE_EN to strobe on accepted
// falling changes too; by default only accepted rising changes strobe.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int CNT_W         = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_raw,
   output logic d_out,
   output logic e_out
);

   // Reject counts the counter cannot represent.
   generate
      if ((STABLE_CYCLES < 1) || (64'(STABLE_CYCLES) >= (64'd1 << CNT_W))) begin : g_bad_param
         $error("switch_debouncer: STABLE_CYCLES out of range for CNT_W");
      end
   endgenerate

   // One bit wider than the counter so cnt+1 never wraps in the compare.
   localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(STABLE_CYCLES);

   logic             samp;
   db_state_e        state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             d_out_d, d_out_q;
   logic             e_out_d, e_out_q;
   logic [CNT_W:0]   cnt_inc;
   logic             rise_acc, fall_acc, strobe;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sw_raw),
      .q     (samp)
   );

   assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

   // Next-state and counter: count samples at the opposite level, drop
   // back to the settled state on any glitch, accept at the limit.
   always_comb begin
      state_d  = state_q;
      cnt_d    = '0;
      rise_acc = 1'b0;
      fall_acc = 1'b0;
      case (state_q)
         LOW, RISE_WAIT: begin
            if (samp != target_level(state_q)) begin
               state_d = LOW;
            end else if (cnt_inc == LIMIT) begin
               state_d  = HIGH;
               rise_acc = 1'b1;
            end else begin
               state_d = RISE_WAIT;
               cnt_d   = cnt_inc[CNT_W-1:0];
            end
         end
         HIGH, FALL_WAIT: begin
            if (samp != target_level(state_q)) begin
               state_d = HIGH;
            end else if (cnt_inc == LIMIT) begin
               state_d  = LOW;
               fall_acc = 1'b1;
            end else begin
               state_d = FALL_WAIT;
               cnt_d   = cnt_inc[CNT_W-1:0];
            end
         end
         default: state_d = LOW;
      endcase
   end

`ifdef SWITCH_DEBOUNCE_FALL_STROBE_EN
   // Strobe both directions so the downstream register follows the switch.
   always_comb strobe = rise_acc | fall_acc;
`else
   // Strobe presses only; the downstream register latches 1.
   always_comb strobe = rise_acc;
`endif

   // Output next values: level moves on acceptance, strobe only that cycle.
   always_comb begin
      d_out_d = d_out_q;
      if (rise_acc) d_out_d = 1'b1;
      if (fall_acc) d_out_d = 1'b0;
      e_out_d = strobe;
   end

   // FSM, counter and output registers; reset discards any pending change.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= LOW;
         cnt_q   <= '0;
         d_out_q <= 1'b0;
         e_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_out_q <= d_out_d;
         e_out_q <= e_out_d;
      end
   end

   assign d_out = d_out_q;
   assign e_out = e_out_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_CYCLES=4, 20 ns clock.
// Expectations on falling changes depend on SWITCH_DEBOUNCE_FALL_STROBE_EN.
module tb_switch_debouncer;

   logic clk = 1'b0;
   logic reset;
   logic sw_raw;
   logic d_out;
   logic e_out;
   logic dreg_q;

   int checks = 0;
   int errors = 0;

`ifdef SWITCH_DEBOUNCE_FALL_STROBE_EN
   localparam logic FALL_STB = 1'b1;
`else
   localparam logic FALL_STB = 1'b0;
`endif

   always #10 clk = ~clk;

   switch_debouncer #(.STABLE_CYCLES(4), .CNT_W(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .sw_raw (sw_raw),
      .d_out  (d_out),
      .e_out  (e_out)
   );

   // Downstream enabled D register fed by the debouncer.
   always @(posedge clk) begin
      if (reset) dreg_q <= 1'b0;
      else if (e_out) dreg_q <= d_out;
   end

   task automatic chk(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b exp %b", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Input already changed before edge 1: level holds d0 with no strobe
   // through edge 5, switches to d1 with strobe stb at edge 6, strobe
   // drops at edge 7.
   task automatic watch(input string tag, input logic d0, input logic d1, input logic stb);
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i < 6) begin
            chk({tag, "_d_wait"}, d_out, d0);
            chk({tag, "_e_wait"}, e_out, 1'b0);
         end else begin
            chk({tag, "_d_edge6"}, d_out, d1);
            chk({tag, "_e_edge6"}, e_out, stb);
         end
      end
      step();
      chk({tag, "_d_edge7"}, d_out, d1);
      chk({tag, "_e_edge7"}, e_out, 1'b0);
   endtask

   task automatic quiet(input string tag, input int n, input logic d0);
      for (int i = 0; i < n; i++) begin
         step();
         chk({tag, "_d"}, d_out, d0);
         chk({tag, "_e"}, e_out, 1'b0);
      end
   endtask

   initial begin
      reset  = 1'b1;
      sw_raw = 1'b1;

      // Reset with switch held high, then accepted as a normal press.
      step();
      chk("rst1_d", d_out, 1'b0);
      chk("rst1_e", e_out, 1'b0);
      step();
      chk("rst2_d", d_out, 1'b0);
      chk("rst2_e", e_out, 1'b0);
      reset = 1'b0;
      watch("rst_rel", 1'b0, 1'b1, 1'b1);
      chk("rst_rel_reg", dreg_q, 1'b1);

      // Release from HIGH.
      sw_raw = 1'b0;
      watch("rel", 1'b1, 1'b0, FALL_STB);
      chk("rel_reg", dreg_q, ~FALL_STB);

      // Clean press.
      sw_raw = 1'b1;
      watch("press", 1'b0, 1'b1, 1'b1);
      chk("press_reg", dreg_q, 1'b1);

      sw_raw = 1'b0;
      watch("rel2", 1'b1, 1'b0, FALL_STB);

      // Bounce: 1 for 3 cycles, 0 for 1, then steady 1.
      sw_raw = 1'b1;
      quiet("bnc_hi", 3, 1'b0);
      sw_raw = 1'b0;
      quiet("bnc_lo", 1, 1'b0);
      sw_raw = 1'b1;
      watch("bnc", 1'b0, 1'b1, 1'b1);

      sw_raw = 1'b0;
      watch("rel3", 1'b1, 1'b0, FALL_STB);

      // Reset while qualifying a press (cnt=2 after edge 4).
      sw_raw = 1'b1;
      quiet("mid_pre", 4, 1'b0);
      reset = 1'b1;
      step();
      chk("mid_rst_d", d_out, 1'b0);
      chk("mid_rst_e", e_out, 1'b0);
      reset = 1'b0;
      watch("mid", 1'b0, 1'b1, 1'b1);

      sw_raw = 1'b0;
      watch("rel4", 1'b1, 1'b0, FALL_STB);

      // Reset on the very edge the press would be accepted.
      sw_raw = 1'b1;
      quiet("sup_pre", 5, 1'b0);
      reset = 1'b1;
      step();
      chk("sup_d", d_out, 1'b0);
      chk("sup_e", e_out, 1'b0);
      reset = 1'b0;
      watch("sup_after", 1'b0, 1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
